// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single strobe/busy memory port.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; otherwise the data port always wins ties.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_rstrb,
  output logic [31:0]       i_rdata,
  output logic              i_rbusy,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [3:0]        d_wmask,
  input  logic              d_rstrb,
  input  logic              d_wstrb,
  output logic [31:0]       d_rdata,
  output logic              d_rbusy,
  output logic              d_wbusy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  output logic              mem_rstrb,
  output logic              mem_wstrb,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_rbusy,
  input  logic              mem_wbusy,
  output logic [1:0]        dbg_state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              i_pend_q, i_pend_d, d_pend_q, d_pend_d;
  logic [ADDR_W-1:0] i_addr_q, i_addr_d, d_addr_q, d_addr_d;
  logic [31:0]       d_wdata_q, d_wdata_d;
  logic [3:0]        d_wmask_q, d_wmask_d;
  logic              d_wr_q, d_wr_d;
  logic              gnt_d_q, gnt_d_d, gnt_wr_q, gnt_wr_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_wmask_q, mem_wmask_d;
  logic [31:0]       i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;
  logic              i_cap, d_cap, i_req, d_req, pick_d, xfer_done;
`ifdef MEM_ARB_RR_EN
  logic              last_d_q, last_d_d;
`endif

  // Requester handshake: a strobe is accepted only while the port's busy is
  // low; busy rises the next cycle and falls once the transfer has completed,
  // and read data is valid from the first cycle busy is low again.
  always_comb begin
    i_cap = i_rstrb & ~i_pend_q;
    d_cap = (d_rstrb | d_wstrb) & ~d_pend_q;
    // A strobe arriving in IDLE is granted the same cycle it is captured.
    i_req = i_pend_q | i_cap;
    d_req = d_pend_q | d_cap;
`ifdef MEM_ARB_RR_EN
    pick_d = d_req & (~i_req | ~last_d_q);
`else
    pick_d = d_req;
`endif

    i_pend_d  = i_pend_q | i_cap;
    d_pend_d  = d_pend_q | d_cap;
    i_addr_d  = i_cap ? i_addr : i_addr_q;
    d_addr_d  = d_cap ? d_addr : d_addr_q;
    d_wdata_d = d_cap ? d_wdata : d_wdata_q;
    d_wmask_d = d_cap ? d_wmask : d_wmask_q;
    // Both data strobes together count as a write.
    d_wr_d    = d_cap ? d_wstrb : d_wr_q;

    state_d     = state_q;
    gnt_d_d     = gnt_d_q;
    gnt_wr_d    = gnt_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    i_rdata_d   = i_rdata_q;
    d_rdata_d   = d_rdata_q;
    xfer_done   = ~(gnt_wr_q ? mem_wbusy : mem_rbusy);
`ifdef MEM_ARB_RR_EN
    last_d_d    = last_d_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (i_req | d_req) begin
          state_d  = S_ISSUE;
          gnt_d_d  = pick_d;
          gnt_wr_d = pick_d & d_wr_d;
`ifdef MEM_ARB_RR_EN
          last_d_d = pick_d;
`endif
          if (pick_d) begin
            mem_addr_d  = d_addr_d;
            mem_wdata_d = d_wdata_d;
            mem_wmask_d = d_wmask_d;
          end else begin
            mem_addr_d  = i_addr_d;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (xfer_done) begin
          state_d = S_IDLE;
          if (gnt_d_q) begin
            d_pend_d = 1'b0;
            if (!gnt_wr_q) d_rdata_d = mem_rdata;
          end else begin
            i_pend_d  = 1'b0;
            i_rdata_d = mem_rdata;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      i_pend_q    <= 1'b0;
      d_pend_q    <= 1'b0;
      i_addr_q    <= '0;
      d_addr_q    <= '0;
      d_wdata_q   <= '0;
      d_wmask_q   <= '0;
      d_wr_q      <= 1'b0;
      gnt_d_q     <= 1'b0;
      gnt_wr_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      i_rdata_q   <= '0;
      d_rdata_q   <= '0;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      i_pend_q    <= i_pend_d;
      d_pend_q    <= d_pend_d;
      i_addr_q    <= i_addr_d;
      d_addr_q    <= d_addr_d;
      d_wdata_q   <= d_wdata_d;
      d_wmask_q   <= d_wmask_d;
      d_wr_q      <= d_wr_d;
      gnt_d_q     <= gnt_d_d;
      gnt_wr_q    <= gnt_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      i_rdata_q   <= i_rdata_d;
      d_rdata_q   <= d_rdata_d;
`ifdef MEM_ARB_RR_EN
      last_d_q    <= last_d_d;
`endif
    end
  end

  assign mem_rstrb = (state_q == S_ISSUE) & ~gnt_wr_q;
  assign mem_wstrb = (state_q == S_ISSUE) & gnt_wr_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign i_rbusy   = i_pend_q;
  assign d_rbusy   = d_pend_q & ~d_wr_q;
  assign d_wbusy   = d_pend_q & d_wr_q;
  assign dbg_state = state_q;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester memory arbiter that lets the rv32i instruction fetch port and data load/store port share a single `ram` instance. It sits between the CPU's `mem_i_*` and `mem_d_*` buses and one memory port. It latches strobe-style requests, serialises them through a small FSM, and returns read data with per-port busy handshakes.

## Interface

Parameters:
- `ADDR_W`, 32, address width on all ports; data is fixed at 32 bits, write mask at 4 bits.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `i_addr`  in  ADDR_W  instruction fetch address.
- `i_rstrb`  in  1  one-cycle instruction read request.
- `i_rdata`  out  32  instruction read data.
- `i_rbusy`  out  1  instruction request outstanding.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  32  store data.
- `d_wmask`  in  4  byte enables for stores.
- `d_rstrb`  in  1  one-cycle data read request.
- `d_wstrb`  in  1  one-cycle data write request.
- `d_rdata`  out  32  load data.
- `d_rbusy`  out  1  data read outstanding.
- `d_wbusy`  out  1  data write outstanding.
- `mem_addr`  out  ADDR_W  address to ram.
- `mem_wdata`  out  32  write data to ram.
- `mem_wmask`  out  4  byte enables to ram.
- `mem_rstrb`  out  1  read strobe to ram.
- `mem_wstrb`  out  1  write strobe to ram.
- `mem_rdata`  in  32  ram read data.
- `mem_rbusy`  in  1  ram read in progress.
- `mem_wbusy`  in  1  ram write in progress.

## Operation

- **Request capture.** Per port, a strobe sampled high while that port is not pending does three things:
  - sets that port's `pend` flag;
  - latches address, and for the data port also wdata, wmask and the op (read/write);
  - sets the port's busy output from the next cycle.
- **Illegal strobes.**
  - A strobe while the port is already pending is dropped and the latched request is unchanged.
  - `d_rstrb` and `d_wstrb` together are treated as a write.
- **FSM states.**
  - `IDLE`: if any `pend` is set, pick the winner and go to `ISSUE`; otherwise stay.
  - `ISSUE`: drive the winner's latched request on `mem_*` with exactly one of `mem_rstrb`/`mem_wstrb` high for this one cycle, then go to `WAIT`.
  - `WAIT`: watch the busy signal for the op in flight (`mem_rbusy` for reads, `mem_wbusy` for writes). On the first cycle it is low:
    - for a read, capture `mem_rdata` into the winner's rdata register;
    - clear the winner's `pend`;
    - go to `IDLE`.
- **Bus hold.** `mem_addr`, `mem_wdata` and `mem_wmask` hold the granted request throughout `ISSUE` and `WAIT`, and the last value in `IDLE`.
- **Busy outputs.**
  - `i_rbusy` = instruction `pend`.
  - `d_rbusy` = data `pend` with op read.
  - `d_wbusy` = data `pend` with op write.
- **Read data.** `i_rdata`/`d_rdata` are registers that hold their value until the next completed read on that port.
- **Concurrency.** A strobe arriving on the non-granted port during `ISSUE`/`WAIT` is captured normally and served after the current transfer.
- **Reset (`rst` low, any state, including mid-transfer):**
  - both `pend` flags cleared and FSM to `IDLE`;
  - `mem_rstrb` = `mem_wstrb` = 0;
  - all busy outputs 0;
  - `i_rdata`, `d_rdata` = 0;
  - `mem_addr`, `mem_wdata`, `mem_wmask` = 0.

  An aborted memory access is abandoned, not replayed.

## Timing

- Strobe sampled at cycle N → port busy high from N+1.
- From `IDLE`, `ISSUE` is in cycle N+1 (`mem_*strb` high in N+1), and `WAIT` starts in N+2.
- With a zero-wait ram (busy low in N+2), data is captured at the end of N+2. Port busy is low and rdata valid in N+3.
  - Best-case latency: 3 cycles.
  - Throughput: one transfer per 3 cycles.
- Each ram busy cycle in `WAIT` adds one cycle of latency.
- A loser pending during a transfer is issued in the cycle after `WAIT`→`IDLE`. `IDLE` always lasts exactly one cycle when a request is pending.
- Requesters sample rdata only in a cycle where their busy is low after having seen it high.

## Configuration

- `MEM_ARB_RR_EN` defined: round-robin.
  - When both ports are pending in `IDLE`, the port not granted last wins.
  - The last-grant flag resets to "instruction", so data wins the first tie.
- Undefined: fixed priority; the data port always wins ties.
  - Instruction fetch may starve under back-to-back data traffic; this is acceptable because the CPU stalls fetch during loads/stores.

## Test plan

- **Single fetch.** Reset, `i_addr`=0x10, `i_rstrb` pulse at N, ram returns 0x00000013 zero-wait → `mem_rstrb` high only in N+1 with `mem_addr`=0x10; `i_rbusy` high N+1..N+2; `i_rdata`=0x00000013 with `i_rbusy` low at N+3.
- **Store with mask.** `d_wstrb` at N, `d_addr`=0x100, `d_wdata`=0xDEADBEEF, `d_wmask`=4'b0011 → `mem_wstrb` at N+1 with the same addr/data/mask; `d_wbusy` clears at N+3; a read of 0x100 returns 0x0000BEEF over zeroed ram.
- **Simultaneous strobes.** `i_rstrb` and `d_rstrb` at the same N:
  - without `MEM_ARB_RR_EN`: data issued at N+1, instruction at N+4;
  - with it: first tie to data, second tie to instruction.
- **Wait states.** Ram holds `mem_rbusy` high for 3 cycles after the strobe → requester busy extends by 3 cycles; rdata is captured only on the first busy-low cycle; no second `mem_rstrb`.
- **Illegal strobes.** A second `i_rstrb` with a different address while `i_rbusy` is high → ignored; only one `mem_rstrb`, using the original address.
- **Reset mid-transfer.** Pull `rst` low during `WAIT` of a data read → all busy outputs and strobes go 0 immediately; rdata=0; after release, no memory access occurs without a new strobe.
